byte_frame_aligner: RTL and testbench

- Sits directly downstream of the serial-to-parallel shift register. Consumes its 8-bit parallel window plus a per-bit strobe.
- Hunts for a sync byte, then locks to byte boundaries and extracts fixed-length frames of payload bytes.
- Buffers the payload bytes in a small FIFO with a valid/ready output toward the packet layer.

---
 rtl/byte_frame_aligner_pkg.sv | 22 ++
 rtl/byte_frame_aligner_fifo.sv | 69 ++++++
 rtl/byte_frame_aligner.sv | 127 ++++++++++++
 tb/tb_byte_frame_aligner.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_frame_aligner_pkg.sv
// Shared types and constants for the byte frame aligner.
package byte_frame_aligner_pkg;

  // Aligner FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  // Default frame-start pattern.
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // One output FIFO entry: start-of-frame flag plus payload byte.
  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/byte_frame_aligner_fifo.sv
// Synchronous first-word-fall-through FIFO with a sticky overflow flag.
// A push while full is accepted only if the head is popped in the same cycle;
// otherwise the word is dropped and overflow is set (set wins over clear).
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  input  logic             clr_overflow,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign head_valid = (count != '0);
  assign full       = (count == FULL_CNT);
  assign do_pop     = head_valid && pop_ready;
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && full && !do_pop;
  // Head is gated so an empty FIFO presents zeros rather than stale storage.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage write; the array needs no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a drop sets it, clr_overflow clears it, set wins.
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync)       overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: rtl/byte_frame_aligner.sv
// Byte frame aligner: hunts for a sync byte in the shift-register window,
// locks to byte boundaries, extracts FRAME_BYTES payload bytes per frame and
// flywheels through up to MISS_LIMIT-1 missed sync bytes before relocking.
//
// Output handshake: out_valid/out_data/out_sof describe the FIFO head; a byte
// transfers on every rising edge where out_valid && out_ready. out_valid never
// drops without a transfer except on reset, and the head is stable while held.
module byte_frame_aligner
  import byte_frame_aligner_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int         FRAME_BYTES = 16,
  parameter int         MISS_LIMIT  = 3,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       enable,
  input  logic [7:0] par_data,
  input  logic       par_valid,
  input  logic       clr_overflow,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       locked,
  output logic       overflow,
  output state_t     fsm_state
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);
  localparam logic [2:0] MISS_LIM  = 3'(MISS_LIMIT);

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [2:0]  miss_cnt;
  logic [2:0]  miss_inc;
  logic        push;
  fifo_entry_t push_entry;
  fifo_entry_t head;

  assign miss_inc   = miss_cnt + 3'd1;
  // A payload byte is complete on the strobe that brings bit_cnt past 7.
  assign push       = enable && par_valid && (state == ST_LOCKED) && (bit_cnt == 3'd7);
  assign push_entry = {(byte_cnt == 8'd0), par_data};
  assign fsm_state  = state;
  assign out_data   = head.data;
  assign out_sof    = head.sof;

  // Alignment FSM with its bit/byte/miss counters; locked is registered alongside.
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      state    <= ST_HUNT;
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
      miss_cnt <= 3'd0;
      locked   <= 1'b0;
    end else if (!enable) begin
      state    <= ST_HUNT;
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
      miss_cnt <= 3'd0;
      locked   <= 1'b0;
    end else if (par_valid) begin
      case (state)
        ST_HUNT: begin
          if (par_data == SYNC_WORD) begin
            state    <= ST_LOCKED;
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
            miss_cnt <= 3'd0;
            locked   <= 1'b1;
          end
        end
        ST_LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == LAST_BYTE) begin
              state   <= ST_CHECK;
              bit_cnt <= 3'd0;
            end
          end
        end
        ST_CHECK: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
            if (par_data == SYNC_WORD) begin
              miss_cnt <= 3'd0;
              state    <= ST_LOCKED;
            end else if (miss_inc == MISS_LIM) begin
              miss_cnt <= 3'd0;
              state    <= ST_HUNT;
              locked   <= 1'b0;
            end else begin
              miss_cnt <= miss_inc;
              state    <= ST_LOCKED;
            end
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  byte_fifo #(
    .WIDTH (FIFO_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_sync   (reset_sync),
    .push         (push),
    .push_data    (push_entry),
    .pop_ready    (out_ready),
    .clr_overflow (clr_overflow),
    .head_data    (head),
    .head_valid   (out_valid),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_byte_frame_aligner.sv
// Testbench for byte_frame_aligner: directed scenarios plus randomized bit
// streams, checked every cycle against a position-based frame model.
module tb_byte_frame_aligner;
  import byte_frame_aligner_pkg::*;

  localparam int         FB    = 16;
  localparam int         ML    = 3;
  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_sync = 1'b0;
  logic       enable;
  logic [7:0] par_data;
  logic       par_valid;
  logic       clr_overflow;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       overflow;
  state_t     fsm_state;

  always #5 clk = ~clk;

  byte_frame_aligner #(
    .SYNC_WORD   (SYNC),
    .FRAME_BYTES (FB),
    .MISS_LIMIT  (ML),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_sync   (reset_sync),
    .enable       (enable),
    .par_data     (par_data),
    .par_valid    (par_valid),
    .clr_overflow (clr_overflow),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .locked       (locked),
    .overflow     (overflow),
    .fsm_state    (fsm_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Once locked at strobe index 'anchor', payload byte k (1..FB) completes at
  // strobe anchor+8k and the sync check falls at anchor+8(FB+1).
  logic [8:0] exp_q[$];
  logic [8:0] seen_q[$];
  bit         m_locked = 1'b0;
  bit         m_ovf = 1'b0;
  int         strobe_n = 0;
  int         anchor = 0;
  int         misses = 0;

  always @(negedge reset_sync) begin
    exp_q.delete();
    m_locked = 1'b0;
    m_ovf    = 1'b0;
    misses   = 0;
  end

  always @(posedge clk) begin : model
    int         d;
    int         k;
    bit         m_push;
    bit         m_pop;
    bit         m_drop;
    logic [8:0] ent;
    if (reset_sync) begin
      m_push = 1'b0;
      ent    = '0;
      if (!enable) begin
        m_locked = 1'b0;
      end else if (par_valid) begin
        strobe_n++;
        if (!m_locked) begin
          if (par_data == SYNC) begin
            m_locked = 1'b1;
            anchor   = strobe_n;
            misses   = 0;
          end
        end else begin
          d = strobe_n - anchor;
          if (d % 8 == 0) begin
            k = d / 8;
            if (k <= FB) begin
              m_push = 1'b1;
              ent    = {(k == 1), par_data};
            end else if (par_data == SYNC) begin
              misses = 0;
              anchor = strobe_n;
            end else begin
              misses++;
              if (misses == ML) begin
                m_locked = 1'b0;
                misses   = 0;
              end else begin
                anchor = strobe_n;
              end
            end
          end
        end
      end
      m_pop  = (exp_q.size() > 0) && out_ready;
      m_drop = m_push && (exp_q.size() == DEPTH) && !m_pop;
      if (m_drop)            m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push && !m_drop) exp_q.push_back(ent);
    end
  end

  // Compare process: outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin : compare
    logic [8:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 9'h000;
    chk("out_valid", out_valid, (exp_q.size() > 0));
    chk("head", {out_sof, out_data}, head);
    chk("locked", locked, m_locked);
    chk("overflow", overflow, m_ovf);
    chk("fsm_hunt", (fsm_state == ST_HUNT), !m_locked);
    if (out_valid && out_ready) seen_q.push_back({out_sof, out_data});
  end

  // ---------------- driver tasks ----------------
  logic [7:0] shreg = 8'h00;
  int         ready_mode = 1;

  task automatic tick();
    @(posedge clk);
    #2;
    par_valid    = 1'b0;
    clr_overflow = 1'b0;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b);
    tick();
    shreg     = {shreg[6:0], b};
    par_data  = shreg;
    par_valid = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap = 0);
    for (int i = 7; i >= 0; i--) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_bit(v[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < FB; i++) send_byte(base + 8'(i));
  endtask

  // Literal expectations for consumed bytes: base, base+1, ... with sof on the first.
  task automatic check_seen(input string name, input logic [7:0] base, input int n);
    chk({name, "_count"}, seen_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < seen_q.size()) chk(name, seen_q[i], {(i == 0), base + 8'(i)});
    end
    seen_q.delete();
  endtask

  task automatic drop_enable(input int n);
    tick();
    enable = 1'b0;
    idle(n);
    enable = 1'b1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] b5;
  logic [7:0] sw;
  int         r;

  initial begin
    enable       = 1'b1;
    par_valid    = 1'b0;
    par_data     = 8'h00;
    clr_overflow = 1'b0;
    out_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_sof, out_data}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overflow", overflow, 0);
    reset_sync = 1'b1;

    // Acquire lock and deliver frame 00..0F.
    ready_mode = 1;
    seen_q.delete();
    send_byte(SYNC);
    chk("lock_before_edge", locked, 0);
    tick();
    chk("lock_after_edge", locked, 1);
    send_frame(8'h00);
    idle(8);
    check_seen("frame1", 8'h00, 16);

    // Repeat frame after a good sync.
    send_byte(SYNC);
    send_frame(8'h30);
    idle(8);
    check_seen("frame2", 8'h30, 16);
    chk("frame2_locked", locked, 1);

    // Three missed syncs: two flywheel frames, then loss of lock.
    send_byte(8'h3C);
    send_frame(8'h40);
    idle(8);
    check_seen("fly1", 8'h40, 16);
    send_byte(8'h3C);
    send_frame(8'h50);
    idle(8);
    check_seen("fly2", 8'h50, 16);
    chk("lock_after_2miss", locked, 1);
    send_byte(8'h3C);
    chk("lock_before_3miss", locked, 1);
    tick();
    chk("lock_after_3miss", locked, 0);
    for (int i = 0; i < FB; i++) send_byte(8'h00);
    idle(4);
    chk("no_push_unlocked", seen_q.size(), 0);

    // Overflow: 6 bytes into a 4-deep FIFO with no consumer.
    ready_mode = 0;
    tick();
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
    tick();
    chk("ovf_after4", overflow, 0);
    send_byte(8'h74);
    tick();
    chk("ovf_after5", overflow, 1);
    send_byte(8'h75);
    tick();
    ready_mode = 1;
    idle(8);
    check_seen("ovf_drain", 8'h70, 4);
    chk("ovf_sticky", overflow, 1);
    tick();
    clr_overflow = 1'b1;
    tick();
    chk("ovf_cleared", overflow, 0);
    drop_enable(2);
    chk("hunt_after_disable", locked, 0);

    // Full FIFO with push and pop on the same edge.
    ready_mode = 0;
    tick();
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i));
    b5 = 8'h84;
    for (int i = 7; i >= 1; i--) send_bit(b5[i]);
    send_bit(b5[0]);
    out_ready = 1'b1;
    tick();
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_valid", out_valid, 1);
    ready_mode = 1;
    idle(8);
    check_seen("full_pp", 8'h80, 5);
    drop_enable(2);

    // Asynchronous reset mid-frame.
    ready_mode = 0;
    tick();
    send_byte(SYNC);
    for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i));
    tick();
    chk("prerst_ovf", overflow, 1);
    chk("prerst_locked", locked, 1);
    for (int i = 0; i < 3; i++) send_bit(1'(i == 0));
    #2;
    reset_sync = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_locked", locked, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_data", {out_sof, out_data}, 0);
    @(posedge clk);
    #2;
    reset_sync = 1'b1;
    par_valid  = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    idle(3);
    chk("post_rst_hunt", locked, 0);
    chk("post_rst_empty", out_valid, 0);
    seen_q.delete();

    // Randomized streams.
    for (int seg = 0; seg < 60; seg++) begin
      ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        for (int i = 0; i < $urandom_range(1, 24); i++) begin
          idle($urandom_range(0, 1));
          send_bit(1'($urandom_range(0, 1)));
        end
      end else if (r <= 6) begin
        sw = ($urandom_range(0, 4) == 0) ? 8'($urandom) : SYNC;
        send_byte(sw, 1);
        for (int i = 0; i < FB; i++) send_byte(8'($urandom), $urandom_range(0, 1));
      end else if (r == 7) begin
        send_byte(8'($urandom), 2);
      end else if (r == 8) begin
        tick();
        enable = 1'b0;
        for (int i = 0; i < $urandom_range(1, 5); i++) send_bit(1'($urandom_range(0, 1)));
        tick();
        enable = 1'b1;
      end else begin
        tick();
        clr_overflow = 1'b1;
      end
      seen_q.delete();
    end

    ready_mode = 1;
    idle(20);
    chk("final_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
